mult_sequencer: RTL
===================

Name: mult_sequencer

Overview:
- Control FSM for the shift-add signed multiplier datapath: the A/B shift registers, the X sign flop and the add/subtract adder.
- Sequences one complete multiply per Run press: clear A/X, then WIDTH add-then-shift iterations, then hold the result.
- Sits between the button synchronizers and the register unit.
- Drives the datapath's Add/Sub/Shift/ClearA/Clr_Ld strobes and reports Busy/Done for the board LEDs and the bench.

Parameters:
- WIDTH, 8, operand width in bits; equals the number of add/shift iterations.
- CW, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset, from the synchronized button.
- Run  in  1  synchronized, active-high start level.
- ClearA_LoadB  in  1  synchronized, active-high load-B/clear-A level.
- M  in  1  current multiplier LSB, B[0], from the register unit.
- Clr_Ld  out  1  load B from switches and clear A/X.
- ClearA  out  1  clear A and X.
- Add  out  1  load A/X with A+S.
- Sub  out  1  load A/X with A-S.
- Shift  out  1  arithmetic right shift of X:A:B.
- Busy  out  1  multiply in progress.
- Done  out  1  product valid in A:B.
- Iter  out  CW  current iteration index, 0..WIDTH-1.

Behaviour:
- States are IDLE, CLEAR, ADD, SHIFT, HOLD. There is one state register and one CW-bit counter (cnt). Both update only on the rising edge of Clk.
- Reset=1 at an edge, in any state including mid-multiply, gives state=IDLE and cnt=0 on the next cycle. Every output is 0 in IDLE with Run=0 and ClearA_LoadB=0, so all outputs are 0 after reset.
- IDLE:
  - Run=1 moves to CLEAR.
  - Run has priority over ClearA_LoadB. When both are 1, the FSM goes to CLEAR and Clr_Ld stays 0 that cycle.
  - Otherwise Clr_Ld=ClearA_LoadB, combinationally and level-driven, for as long as it is held.
- CLEAR: lasts 1 cycle. ClearA=1, cnt is loaded with 0, next state is ADD.
- ADD: lasts 1 cycle, next state is SHIFT.
  - When cnt<WIDTH-1: Add=M, Sub=0.
  - When cnt==WIDTH-1: Sub=M, Add=0.
  - Add and Sub are Mealy on M and are never both 1.
- SHIFT: lasts 1 cycle with Shift=1.
  - When cnt==WIDTH-1, next state is HOLD.
  - Otherwise cnt increments and the FSM returns to ADD.
- HOLD:
  - Done=1. Stay while Run=1; go to IDLE when Run=0.
  - There is no restart without Run being released, so a held Run produces exactly one multiply.
  - Clr_Ld=0 in HOLD.
- Busy=1 in CLEAR, ADD and SHIFT, and 0 otherwise. Iter=cnt.
- Busy and Done are never both 1.
- Latency: with Run=1 sampled in IDLE at edge t:
  - CLEAR is in cycle t+1.
  - ADD_i is in cycle t+2+2i and SHIFT_i in cycle t+3+2i.
  - HOLD starts at t+2+2·WIDTH (t+18 for WIDTH=8).
  - Total busy time is 2·WIDTH+1 cycles.
- ClearA_LoadB is ignored in CLEAR, ADD, SHIFT and HOLD.
- Changes in Run during CLEAR, ADD and SHIFT are ignored. Releasing Run mid-multiply does not abort it; only Reset aborts.
- At most one of Clr_Ld, ClearA, Add, Sub and Shift is 1 in any cycle.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, Iter=0.
- Hold ClearA_LoadB=1 for 3 cycles in IDLE -> Clr_Ld=1 for exactly those 3 cycles; no other strobe asserts.
- WIDTH=8, M stream per iteration 1,1,1,0,0,0,0,0 (B=0x07), Run pulse at edge t:
  - ClearA=1 at t+1.
  - Add=1 at t+2, t+4 and t+6; no other Add.
  - Sub never asserts.
  - Shift=1 at each odd cycle t+3..t+17.
  - Done=1 from t+18.
- M stream 0,0,0,0,0,0,0,1 (B=0x80) -> Add never asserts; Sub=1 only at t+16; Done=1 at t+18.
- Hold Run=1 for 40 cycles, with ClearA_LoadB=1 throughout:
  - Exactly one multiply runs and Clr_Ld stays 0.
  - Done stays 1 until the cycle after Run=0; IDLE follows and Clr_Ld=1 once the FSM is back in IDLE.
- Assert Reset at t+7 mid-multiply -> at t+8 state is IDLE with all outputs 0; a following Run pulse starts a full 17-cycle multiply from ClearA.

Source files
------------

// File: rtl/mult_sequencer.sv
// Control FSM for the shift-add signed multiplier: clears A/X, runs WIDTH
// add-then-shift iterations (subtracting on the last), then holds the product.
module mult_sequencer #(
   parameter  int WIDTH = 8,
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Run,
   input  logic          ClearA_LoadB,
   input  logic          M,
   output logic          Clr_Ld,
   output logic          ClearA,
   output logic          Add,
   output logic          Sub,
   output logic          Shift,
   output logic          Busy,
   output logic          Done,
   output logic [CW-1:0] Iter
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ADD,
      S_SHIFT,
      S_HOLD
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          last;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   assign last = (cnt == LAST);
   assign Iter = cnt;

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      Clr_Ld     = 1'b0;
      ClearA     = 1'b0;
      Add        = 1'b0;
      Sub        = 1'b0;
      Shift      = 1'b0;
      Busy       = 1'b0;
      Done       = 1'b0;
      unique case (state)
         S_IDLE: begin
            // Run wins over a concurrent load request
            if (Run) state_next = S_CLEAR;
            else     Clr_Ld     = ClearA_LoadB;
         end
         S_CLEAR: begin
            Busy       = 1'b1;
            ClearA     = 1'b1;
            cnt_next   = '0;
            state_next = S_ADD;
         end
         S_ADD: begin
            Busy = 1'b1;
            // sign bit of the multiplier has negative weight
            if (last) Sub = M;
            else      Add = M;
            state_next = S_SHIFT;
         end
         S_SHIFT: begin
            Busy  = 1'b1;
            Shift = 1'b1;
            if (last) begin
               state_next = S_HOLD;
            end else begin
               cnt_next   = cnt + CW'(1);
               state_next = S_ADD;
            end
         end
         S_HOLD: begin
            Done = 1'b1;
            if (!Run) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule
